// File: rtl/pipe_phy_pkg.sv
// -----------------------------------------------------------------------------
// pipe_phy_pkg
// Shared definitions for the PIPE PHY control responder: PowerDown encodings,
// RxStatus codes, the per-lane FSM state type and a small sizing helper.
// No ports.
// -----------------------------------------------------------------------------
package pipe_phy_pkg;

    localparam logic [3:0] P0  = 4'b0000;
    localparam logic [3:0] P0s = 4'b0001;
    localparam logic [3:0] P1  = 4'b0010;
    localparam logic [3:0] P2  = 4'b0011;

    localparam logic [2:0] RXSTAT_OK       = 3'b000;
    localparam logic [2:0] RXSTAT_DETECTED = 3'b011;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_DET_WAIT = 3'd2,
        ST_PD_WAIT  = 3'd3,
        ST_REPORT   = 3'd4
    } lane_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pipe_phy_ctrl_responder_if.sv
// -----------------------------------------------------------------------------
// pipe_phy_ctrl_responder_if
// PIPE control bundle between MAC (master) and PHY responder (slave).
//   PowerDown            MAC->PHY  4 bits per lane, lane i at [4i+3:4i]
//   TxDetectRx_Loopback  MAC->PHY  per-lane receiver-detect request
//   TxElecIdle           MAC->PHY  per-lane transmitter electrical idle
//   lane_present         cfg->PHY  per-lane far-end receiver present
//   PhyStatus            PHY->MAC  per-lane completion strobe
//   RxStatus             PHY->MAC  3 bits per lane, lane i at [3i+2:3i]
// -----------------------------------------------------------------------------
interface pipe_phy_ctrl_responder_if #(
    parameter int LANESNUMBER = 16
);
    logic [4*LANESNUMBER-1:0] PowerDown;
    logic [LANESNUMBER-1:0]   TxDetectRx_Loopback;
    logic [LANESNUMBER-1:0]   TxElecIdle;
    logic [LANESNUMBER-1:0]   lane_present;
    logic [LANESNUMBER-1:0]   PhyStatus;
    logic [3*LANESNUMBER-1:0] RxStatus;

    modport master (
        output PowerDown, TxDetectRx_Loopback, TxElecIdle, lane_present,
        input  PhyStatus, RxStatus
    );

    modport slave (
        input  PowerDown, TxDetectRx_Loopback, TxElecIdle, lane_present,
        output PhyStatus, RxStatus
    );
endinterface

// File: rtl/pipe_phy_lane_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_phy_lane_ctrl
// One PIPE lane: answers receiver-detect requests and PowerDown changes with a
// single-cycle PhyStatus strobe after a fixed latency; holds PhyStatus high for
// RESET_HOLD cycles after reset release.
//   pclk, reset     clock, async active-high reset
//   i_power_down    lane PowerDown code
//   i_det_req       TxDetectRx_Loopback for this lane
//   i_elec_idle     TxElecIdle for this lane
//   i_lane_present  far-end receiver present
//   o_phy_status    PhyStatus for this lane
//   o_rx_status     RxStatus for this lane
//
// state       | meaning
// ST_HOLD     | post-reset PhyStatus hold
// ST_IDLE     | waiting for detect edge or PowerDown change
// ST_DET_WAIT | receiver detect in progress
// ST_PD_WAIT  | PowerDown transition in progress
// ST_REPORT   | one-cycle completion strobe
// -----------------------------------------------------------------------------
module pipe_phy_lane_ctrl
    import pipe_phy_pkg::*;
#(
    parameter int DETECT_LATENCY = 8,
    parameter int PD_LATENCY     = 4,
    parameter int RESET_HOLD     = 4
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [3:0] i_power_down,
    input  logic       i_det_req,
    input  logic       i_elec_idle,
    input  logic       i_lane_present,
    output logic       o_phy_status,
    output logic [2:0] o_rx_status
);

    localparam int MAX_CNT = max3(DETECT_LATENCY, PD_LATENCY, RESET_HOLD);
    localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;

    // Wait states count down to zero; entry load is LATENCY-1 so the strobe
    // lands LATENCY+1 cycles after the input edge that triggered it.
    localparam logic [CNT_W-1:0] DET_LOAD = CNT_W'((DETECT_LATENCY > 0) ? DETECT_LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] PD_LOAD  = CNT_W'((PD_LATENCY > 0) ? PD_LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(RESET_HOLD);

    lane_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_pd_prev;
    logic             r_det_prev;
    logic [2:0]       r_rx_status, w_rx_nxt;
    logic             w_pd_chg, w_det_ok, w_cnt_zero;

    assign w_pd_chg   = (i_power_down != r_pd_prev);
    assign w_det_ok   = i_det_req & ~r_det_prev & i_elec_idle & (i_power_down == P1);
    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_HOLD: begin
                // Up-count from the reset value of zero; the terminal compare
                // stops it, so it cannot wrap.
                if (r_cnt == HOLD_TC) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                // PowerDown change takes priority over a same-cycle detect edge.
                if (w_pd_chg) begin
                    w_state_nxt = ST_PD_WAIT;
                    w_cnt_nxt   = PD_LOAD;
                end else if (w_det_ok) begin
                    w_state_nxt = ST_DET_WAIT;
                    w_cnt_nxt   = DET_LOAD;
                end
            end
            ST_DET_WAIT, ST_PD_WAIT: begin
                if (w_pd_chg) begin
                    w_state_nxt = ST_PD_WAIT;
                    w_cnt_nxt   = PD_LOAD;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_REPORT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_REPORT: begin
                // A change landing on the strobe cycle would otherwise be lost,
                // since r_pd_prev has already absorbed it by the time IDLE runs.
                if (w_pd_chg) begin
                    w_state_nxt = ST_PD_WAIT;
                    w_cnt_nxt   = PD_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // lane_present is captured on the transition into REPORT.
    always_comb begin
        w_rx_nxt = RXSTAT_OK;
        if (r_state == ST_DET_WAIT && w_state_nxt == ST_REPORT && i_lane_present)
            w_rx_nxt = RXSTAT_DETECTED;
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_pd_prev   <= i_power_down;
            r_det_prev  <= 1'b0;
            r_rx_status <= RXSTAT_OK;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pd_prev   <= i_power_down;
            r_det_prev  <= i_det_req;
            r_rx_status <= w_rx_nxt;
        end
    end

    assign o_phy_status = (r_state == ST_HOLD) || (r_state == ST_REPORT);
    assign o_rx_status  = r_rx_status;

endmodule

// File: rtl/pipe_phy_ctrl_responder.sv
// -----------------------------------------------------------------------------
// pipe_phy_ctrl_responder
// PIPE PHY control responder: LANESNUMBER independent lane controllers, the
// top level only slices the bus per lane.
//   pclk   PIPE clock
//   reset  async active-high reset
//   bus    pipe_phy_ctrl_responder_if slave modport (PowerDown,
//          TxDetectRx_Loopback, TxElecIdle, lane_present in;
//          PhyStatus, RxStatus out)
// -----------------------------------------------------------------------------
module pipe_phy_ctrl_responder #(
    parameter int LANESNUMBER    = 16,
    parameter int DETECT_LATENCY = 8,
    parameter int PD_LATENCY     = 4,
    parameter int RESET_HOLD     = 4
) (
    input logic                       pclk,
    input logic                       reset,
    pipe_phy_ctrl_responder_if.slave  bus
);

    wire [LANESNUMBER-1:0]   w_phy_status;
    wire [3*LANESNUMBER-1:0] w_rx_status;

    for (genvar gi = 0; gi < LANESNUMBER; gi++) begin : g_lane
        pipe_phy_lane_ctrl #(
            .DETECT_LATENCY (DETECT_LATENCY),
            .PD_LATENCY     (PD_LATENCY),
            .RESET_HOLD     (RESET_HOLD)
        ) u_lane (
            .pclk           (pclk),
            .reset          (reset),
            .i_power_down   (bus.PowerDown[4*gi +: 4]),
            .i_det_req      (bus.TxDetectRx_Loopback[gi]),
            .i_elec_idle    (bus.TxElecIdle[gi]),
            .i_lane_present (bus.lane_present[gi]),
            .o_phy_status   (w_phy_status[gi]),
            .o_rx_status    (w_rx_status[3*gi +: 3])
        );
    end

    assign bus.PhyStatus = w_phy_status;
    assign bus.RxStatus  = w_rx_status;

endmodule

// File: tb/tb_pipe_phy_ctrl_responder.sv
// -----------------------------------------------------------------------------
// tb_pipe_phy_ctrl_responder
// Directed bench for pipe_phy_ctrl_responder with 16 lanes and default
// latencies. Inputs change 1 time unit after a rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_phy_ctrl_responder;
    import pipe_phy_pkg::*;

    localparam int N = 16;

    logic pclk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3*N-1:0] exp_det;

    pipe_phy_ctrl_responder_if #(.LANESNUMBER(N)) bus ();

    pipe_phy_ctrl_responder #(
        .LANESNUMBER    (N),
        .DETECT_LATENCY (8),
        .PD_LATENCY     (4),
        .RESET_HOLD     (4)
    ) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_pd(input int lane, input logic [3:0] v);
        bus.PowerDown[4*lane +: 4] = v;
    endtask

    task automatic drive_edge();
        @(posedge pclk);
        #1;
    endtask

    task automatic sample_next();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    initial begin
        exp_det = '0;
        for (int i = 0; i < 8; i++) exp_det[3*i +: 3] = RXSTAT_DETECTED;

        reset                   = 1'b1;
        bus.PowerDown           = {N{P1}};
        bus.TxDetectRx_Loopback = '0;
        bus.TxElecIdle          = '1;
        bus.lane_present        = 16'h00FF;

        #12;
        chk("rst_phy", 64'(bus.PhyStatus), 64'hFFFF);
        chk("rst_rx",  64'(bus.RxStatus),  64'h0);

        // Reset release and HOLD sequence
        drive_edge();
        reset = 1'b0;
        for (int m = 1; m <= 6; m++) begin
            sample_next();
            chk("hold_phy", 64'(bus.PhyStatus), (m <= 4) ? 64'hFFFF : 64'h0);
            chk("hold_rx",  64'(bus.RxStatus),  64'h0);
        end

        // Detect on all lanes, lanes 0-7 present
        drive_edge();
        bus.TxDetectRx_Loopback = '1;
        for (int m = 1; m <= 10; m++) begin
            sample_next();
            chk("det_phy", 64'(bus.PhyStatus), (m == 9) ? 64'hFFFF : 64'h0);
            chk("det_rx",  64'(bus.RxStatus),  (m == 9) ? 64'(exp_det) : 64'h0);
        end
        drive_edge();
        bus.TxDetectRx_Loopback = '0;

        // Lane 3 PowerDown P1->P0
        drive_edge();
        set_pd(3, P0);
        for (int m = 1; m <= 7; m++) begin
            sample_next();
            chk("pd3_phy", 64'(bus.PhyStatus), (m == 5) ? 64'h0008 : 64'h0);
            chk("pd3_rx",  64'(bus.RxStatus),  64'h0);
        end

        // Detect on lane 0 aborted by a PowerDown change four cycles later
        drive_edge();
        bus.TxDetectRx_Loopback = 16'h0001;
        for (int m = 1; m <= 11; m++) begin
            @(posedge pclk);
            if (m == 4) begin
                #1;
                set_pd(0, P0);
            end
            @(negedge pclk);
            chk("abort_phy", 64'(bus.PhyStatus), (m == 9) ? 64'h0001 : 64'h0);
            chk("abort_rx",  64'(bus.RxStatus),  64'h0);
        end
        drive_edge();
        bus.TxDetectRx_Loopback = '0;

        // Lane 5: second PowerDown change restarts the wait, single strobe
        drive_edge();
        set_pd(5, P2);
        for (int m = 1; m <= 10; m++) begin
            @(posedge pclk);
            if (m == 2) begin
                #1;
                set_pd(5, P0);
            end
            @(negedge pclk);
            chk("restart_phy", 64'(bus.PhyStatus), (m == 7) ? 64'h0020 : 64'h0);
        end

        // Lane 6: detect edge and PowerDown change together, PowerDown wins
        drive_edge();
        bus.TxDetectRx_Loopback = 16'h0040;
        set_pd(6, P0);
        for (int m = 1; m <= 10; m++) begin
            sample_next();
            chk("both_phy", 64'(bus.PhyStatus), (m == 5) ? 64'h0040 : 64'h0);
            chk("both_rx",  64'(bus.RxStatus),  64'h0);
        end
        drive_edge();
        bus.TxDetectRx_Loopback = '0;

        // Detect requests that must be ignored: lane 0 in P0, lane 1 not idle
        drive_edge();
        bus.TxElecIdle          = 16'hFFFD;
        bus.TxDetectRx_Loopback = 16'h0003;
        for (int m = 1; m <= 20; m++) begin
            sample_next();
            chk("ign_phy", 64'(bus.PhyStatus), 64'h0);
        end

        // Reset in the middle of a lane 2 detect
        drive_edge();
        bus.TxDetectRx_Loopback = '0;
        bus.TxElecIdle          = '1;
        drive_edge();
        bus.TxDetectRx_Loopback = 16'h0004;
        repeat (3) @(posedge pclk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_phy", 64'(bus.PhyStatus), 64'hFFFF);
        chk("mid_rst_rx",  64'(bus.RxStatus),  64'h0);
        repeat (2) @(posedge pclk);
        #1;
        reset = 1'b0;
        for (int m = 1; m <= 14; m++) begin
            sample_next();
            chk("post_rst_phy", 64'(bus.PhyStatus), (m <= 4) ? 64'hFFFF : 64'h0);
            chk("post_rst_rx",  64'(bus.RxStatus),  64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_phy_ctrl_responder.md
PIPE_PHY_CTRL_RESPONDER -- requirements
Module: pipe_phy_ctrl_responder

Interface
REQ-001 Parameter LANESNUMBER, default 16: number of PIPE lanes.
REQ-002 Parameter DETECT_LATENCY, default 8: pclk cycles from detect request to result.
REQ-003 Parameter PD_LATENCY, default 4: pclk cycles from PowerDown change to completion.
REQ-004 Parameter RESET_HOLD, default 4: pclk cycles PhyStatus stays high after reset release.
REQ-005 pclk  input  1  PIPE clock; the only clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 PowerDown  input  4*LANESNUMBER  per-lane power state from MAC; 4 bits per lane, lane i at [4i+3:4i].
REQ-008 TxDetectRx_Loopback  input  LANESNUMBER  per-lane receiver-detect request.
REQ-009 TxElecIdle  input  LANESNUMBER  per-lane transmitter electrical idle.
REQ-010 lane_present  input  LANESNUMBER  per-lane far-end receiver present (static config).
REQ-011 PhyStatus  output  LANESNUMBER  per-lane completion strobe.
REQ-012 RxStatus  output  3*LANESNUMBER  per-lane status code; lane i at [3i+2:3i].

Function
REQ-013 Each lane SHALL run an independent FSM with states HOLD, IDLE, DET_WAIT, PD_WAIT and REPORT.
REQ-014 HOLD: PhyStatus[i]=1 for RESET_HOLD cycles after reset deasserts, then go to IDLE with PhyStatus[i]=0.
REQ-015 IDLE -> DET_WAIT on a rising edge of TxDetectRx_Loopback[i] while PowerDown lane == P1 (4'b0010) and TxElecIdle[i]=1; a rising edge under any other conditions SHALL be ignored.
REQ-016 IDLE -> PD_WAIT when the PowerDown lane value differs from its registered previous-cycle value.
REQ-017 DET_WAIT/PD_WAIT SHALL count DETECT_LATENCY/PD_LATENCY cycles and then enter REPORT; the first strobe appears exactly LATENCY+1 cycles after the triggering input edge.
REQ-018 REPORT SHALL last one cycle, with PhyStatus[i]=1 and the lane's RxStatus set as follows, then return to IDLE:
- after detect: 3'b011 if lane_present[i]=1, else 3'b000;
- after a PowerDown change: 3'b000.
REQ-019 Outside REPORT and HOLD, PhyStatus[i]=0 and the lane's RxStatus=3'b000.
REQ-020 A PowerDown change during DET_WAIT SHALL abort the detect (no detect strobe) and restart the count as PD_WAIT.
REQ-021 A PowerDown change during PD_WAIT SHALL restart the PD_WAIT count; exactly one strobe is issued.
REQ-022 If a detect edge and a PowerDown change occur in the same cycle in IDLE, the PowerDown change SHALL win.
REQ-023 TxDetectRx_Loopback edges during DET_WAIT, PD_WAIT or REPORT SHALL be ignored, with no queuing.
REQ-024 lane_present SHALL be sampled in the cycle the FSM enters REPORT.
REQ-025 Counters SHALL be sized to $clog2(max latency + 1) bits and SHALL saturate, never wrap.

Reset
REQ-026 While reset=1: all FSMs in HOLD, PhyStatus all ones, RxStatus all zeros, counters zero, previous-PowerDown registers loaded from PowerDown.
REQ-027 Reset asserted mid-operation SHALL immediately abandon any pending detect or PowerDown report, with no strobe issued after release other than the HOLD sequence.

Structure
REQ-028 The shared package pipe_phy_pkg SHALL hold:
- PowerDown encodings P0=4'b0000, P0s=4'b0001, P1=4'b0010, P2=4'b0011;
- RxStatus codes RXSTAT_OK=3'b000, RXSTAT_DETECTED=3'b011;
- the lane FSM state enum.
REQ-029 The per-lane FSM SHALL be the single sub-module pipe_phy_lane_ctrl, instantiated LANESNUMBER times by a generate loop; the top level contains only slicing.

Verification
REQ-030 Reset release -> PhyStatus=16'hFFFF for 4 cycles, then 16'h0000; RxStatus=0 throughout.
REQ-031 PowerDown=P1 on all lanes, TxElecIdle=all ones, lane_present=16'h00FF, TxDetectRx_Loopback 0->all ones -> 9 cycles later PhyStatus=16'hFFFF for one cycle; lanes 0-7 RxStatus=3'b011, lanes 8-15 3'b000.
REQ-032 Lane 3 PowerDown P1->P0 -> PhyStatus[3] pulses exactly 5 cycles later with RxStatus=0; other lanes stay quiet.
REQ-033 Detect on lane 0, PowerDown change on lane 0 four cycles later -> no detect strobe; a single PhyStatus[0] pulse 5 cycles after the change.
REQ-034 Detect request with PowerDown=P0 or TxElecIdle=0 -> no PhyStatus pulse within 20 cycles.
REQ-035 Reset asserted 3 cycles into DET_WAIT -> PhyStatus all ones asynchronously; after release, HOLD sequence only, no RxStatus=3'b011.
